// File: rtl/mio_pkg.sv
// Shared types and constants for the MIO card STEbus front-end: state encoding,
// bus polarity and the card's default decode map.
package mio_pkg;

   typedef enum logic [2:0] {
      RECOVER,
      IDLE,
      ACCESS,
      ACK,
      MISS
   } state_e;

   localparam logic ASSERTED_N = 1'b0;
   localparam logic NEGATED_N  = 1'b1;

   // MIO map: ch0 CompactFlash, ch1 printer, ch2 legacy alias over 0..7, ch3 RTC
   localparam logic [19:0] MIO_BASES = {5'b10000, 5'b00000, 5'b00100, 5'b00000};
   localparam logic [19:0] MIO_MASKS = {5'b11110, 5'b11000, 5'b11100, 5'b11100};
   localparam logic [15:0] MIO_WAITS = {4'd3, 4'd1, 4'd2, 4'd0};

   function automatic int CH_W(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ste_sync.sv
// Two-flop synchroniser for a single asynchronous bus signal.
module ste_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // NOTE: flops take non-blocking assignments so every stage samples the old value of the one before it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/ste_io_decoder.sv
// STEbus slave front-end: windowed chip-select decode, wait states, peripheral
// ready and bus-error timeout generating DATACK*.
module ste_io_decoder
   import mio_pkg::*;
#(
   parameter int                          ADDR_W  = 5,
   parameter int                          NCH     = 4,
   parameter logic [NCH*ADDR_W-1:0]       BASES   = '0,
   parameter logic [NCH*ADDR_W-1:0]       MASKS   = '1,
   parameter int                          WAIT_W  = 4,
   parameter logic [NCH*WAIT_W-1:0]       WAITS   = '0,
   parameter int                          TO_W    = 8,
   parameter int                          TIMEOUT = 200
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              cm0,
   input  logic              ce,
   input  logic [NCH-1:0]    rdy,
   output logic              datack,
   output logic [NCH-1:0]    cs_n,
   output logic              rd,
   output logic              wr,
   output logic              berr,
   output logic [2:0]        chan
);

   localparam int          CHW      = CH_W(NCH);
   localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT);

   state_e            state_q, state_d;
   logic [CHW-1:0]    ch_q, ch_d;
   logic              cm0_q, cm0_d;
   logic [WAIT_W-1:0] cnt_q, cnt_d;
   logic [TO_W-1:0]   tcnt_q, tcnt_d;
   logic              berr_q, berr_d;
   logic [1:0]        rec_q, rec_d;

   logic              ce_s;
   logic              hit;
   logic [CHW-1:0]    hit_ch;
   logic              timeout_hit;
   logic              active;
   logic [WAIT_W-1:0] wait_of [NCH];

   ste_sync #(.RST_VAL(1'b1)) u_ce_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ce),
      .q     (ce_s)
   );

   for (genvar g = 0; g < NCH; g++) begin : g_wait
      assign wait_of[g] = WAITS[g*WAIT_W +: WAIT_W];
   end

   // Scan downwards so the lowest matching channel is the last one written.
   always_comb begin
      hit    = 1'b0;
      hit_ch = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (((addr ^ BASES[i*ADDR_W +: ADDR_W]) & MASKS[i*ADDR_W +: ADDR_W]) == '0) begin
            hit    = 1'b1;
            hit_ch = CHW'(i);
         end
      end
   end

   assign timeout_hit = (32'(tcnt_q) + 32'd1) >= TO_LIMIT;

   // NOTE: every signal written here gets a default first, so no latch is inferred on any path.
   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cm0_d   = cm0_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      berr_d  = 1'b0;
      rec_d   = (rec_q != 2'd0) ? rec_q - 2'd1 : rec_q;
      case (state_q)
         // The synchroniser refills with reset values, so its output is trusted only once rec_q drains.
         RECOVER: if (rec_q == 2'd0 && ce_s != ASSERTED_N) state_d = IDLE;
         IDLE: begin
            if (ce_s == ASSERTED_N) begin
               ch_d    = hit_ch;
               cm0_d   = cm0;
               cnt_d   = wait_of[hit_ch];
               tcnt_d  = '0;
               state_d = hit ? ACCESS : MISS;
            end
         end
         ACCESS: begin
            tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + 1'b1;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            if (ce_s != ASSERTED_N) begin
               state_d = IDLE;
            end else if (cnt_q == '0 && rdy[ch_q]) begin
               state_d = ACK;
            end else if (timeout_hit) begin
               state_d = ACK;
               berr_d  = 1'b1;
            end
         end
         ACK, MISS: if (ce_s != ASSERTED_N) state_d = IDLE;
         default: state_d = RECOVER;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= RECOVER;
         ch_q    <= '0;
         cm0_q   <= 1'b0;
         cnt_q   <= '0;
         tcnt_q  <= '0;
         berr_q  <= 1'b0;
         rec_q   <= 2'd2;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cm0_q   <= cm0_d;
         cnt_q   <= cnt_d;
         tcnt_q  <= tcnt_d;
         berr_q  <= berr_d;
         rec_q   <= rec_d;
      end
   end

   assign active = (state_q == ACCESS) || (state_q == ACK);

   always_comb begin
      cs_n   = {NCH{NEGATED_N}};
      rd     = NEGATED_N;
      wr     = NEGATED_N;
      datack = NEGATED_N;
      chan   = '0;
      if (active) begin
         cs_n[ch_q] = ASSERTED_N;
         if (cm0_q) rd = ASSERTED_N;
         else       wr = ASSERTED_N;
         chan = 3'(ch_q);
      end
      if (state_q == ACK) datack = ASSERTED_N;
   end

   assign berr = berr_q;

endmodule

// File: doc/ste_io_decoder.md
# ste_io_decoder

Parametrised STEbus slave front-end for the MIO card, the next generation of the card's fixed chip-select decoder. It synchronises the bus strobe and decodes `addr` against NCH programmable windows, producing active-low chip selects and read/write strobes. A per-channel wait-state counter, per-channel external ready inputs and a bus-error timeout then generate DATACK*. It sits between the STEbus pins and the on-card peripherals (CompactFlash, printer, RTC, keyboard, sound).

## Interface
- ADDR_W, 5: STEbus address width decoded by the card
- NCH, 4: number of decoded channels (1..8)
- BASES, {NCH{ADDR_W'b0}}: packed base address per channel, channel 0 in LSBs
- MASKS, {NCH{ADDR_W'b1}}: packed compare mask per channel; 1 = bit compared
- WAIT_W, 4: wait-state counter width
- WAITS, {NCH{WAIT_W'd0}}: packed wait states per channel
- TO_W, 8: timeout counter width
- TIMEOUT, 200: cycles in ACCESS before a forced acknowledge
- clk  in  1  card clock
- reset  in  1  synchronous, active-low reset
- addr  in  ADDR_W  STEbus address, stable while ce low
- cm0  in  1  0 = write, 1 = read
- ce  in  1  STEbus strobe, active-low, asynchronous to clk
- rdy  in  NCH  per-channel peripheral ready, active-high
- datack  out  1  DATACK*, active-low
- cs_n  out  NCH  chip selects, active-low, one-hot-low
- rd  out  1  read strobe, active-low
- wr  out  1  write strobe, active-low
- berr  out  1  one-cycle pulse, high when an access ended by timeout
- chan  out  3  index of the active channel, valid while any cs_n is low

## Operation
- ce passes through a 2-flop synchroniser; ce_s is its output. addr and cm0 are sampled only on the edge that leaves IDLE.
- Channel match: ((addr ^ BASE[i]) & MASK[i]) == 0. With several matches, the lowest index wins. With no match, go to MISS.
- States:
  - RECOVER: wait for ce_s = 1, then go to IDLE.
  - IDLE: on ce_s = 0 with a match, go to ACCESS. On ce_s = 0 with no match, go to MISS.
  - ACCESS: cs_n[ch] low. rd low if cm0 = 1, else wr low. Counter cnt loads WAITS[ch] and decrements to 0. When cnt = 0 and rdy[ch] = 1, go to ACK.
  - ACK: datack low while strobes are held. When ce_s = 1, go to IDLE.
  - MISS: no outputs asserted; datack is never driven for foreign addresses. When ce_s = 1, go to IDLE.
- Timeout: tcnt counts edges spent in ACCESS. On reaching TIMEOUT, go to ACK and pulse berr for one cycle. tcnt saturates and clears on entering ACCESS.
- ce_s rising during ACCESS (master abort): go to IDLE, release everything, no berr.

## Timing
- Reset values: datack = 1, cs_n = all 1, rd = 1, wr = 1, berr = 0, chan = 0. Reset state is RECOVER, so an access already in flight when reset is released is never replayed.
- Reset asserted mid-access releases all outputs on that same edge.
- Edge numbering: ce low before edge 1. ce_s is low after edge 2. Leaving IDLE happens on edge 3, so cs_n/rd/wr are valid after edge 3.
- With WAITS = w and rdy held high, datack goes low after edge 4+w.
- rdy low extends ACCESS one cycle per low sample.
- Release: ce high before edge E means ce_s is high after E+1, and all outputs are high after E+2.
- rd and wr are never both low. cs_n and the strobes change on the same edge.

## Structure
- Shared package `mio_pkg`: state enum (RECOVER, IDLE, ACCESS, ACK, MISS), STEbus polarity constants (ASSERTED_N = 1'b0), CH_W function, and the default window constants for the MIO map.
- One sub-module, `ste_sync`: 2-flop synchroniser with parameter RST_VAL, reset to 1 for ce.
- Decode priority encoder and counters live in `ste_io_decoder`.

## Test plan
- Read, channel 1 (BASE 5'b00100, MASK 5'b11100, WAITS 2), rdy = 1 → cs_n = 4'b1101 and rd = 0 after edge 3, datack = 0 after edge 6, and everything high 2 edges after ce rises.
- Write, channel 0, WAITS 0, rdy held 0 for 3 cycles → wr = 0, and datack = 0 after edge 7.
- Unmapped address 5'b11111 → MISS, all outputs stay high for the whole cycle, and the next mapped access completes normally.
- rdy stuck at 0 with TIMEOUT = 10 → datack = 0 after 10 ACCESS cycles, and berr = 1 for exactly one cycle.
- Overlapping windows for ch0 and ch2 → only cs_n[0] asserted, and chan = 0.
- reset = 0 during ACK with ce still low → outputs high on the next edge, and no new access until ce goes high then low again.
